mapper4510_hyper_ctx: RTL
=========================

MAPPER4510_HYPER_CTX -- requirements
Module: mapper4510_hyper_ctx

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port trap_enter, input, 1: one-cycle request to save the user mapper state into the shadow.
REQ-004 SHALL have port trap_exit, input, 1: one-cycle request to restore the shadow into the user mapper.
REQ-005 SHALL have port map, input, 1: high while the mapper is executing a MAP instruction.
REQ-006 SHALL have port map_reg_data, input, 8: user mapper readback byte for the index on map_reg_rd_sel.
REQ-007 SHALL have port map_reg_rd_sel, output, 2: readback index (3=A, 2=X, 1=Y, 0=Z).
REQ-008 SHALL have ports map_reg_write_sel (output, 2), hypervisor_load_user_reg (output, 1) and map_wr_data (output, 8): the mapper write strobe, its index and its data byte.
REQ-009 SHALL have ports shadow_rd_sel (input, 2) and shadow_rd_data (output, 8): combinational hypervisor read of the shadow byte.
REQ-010 SHALL have ports shadow_we (input, 1), shadow_wr_sel (input, 2) and shadow_wr_data (input, 8): hypervisor write to the shadow.
REQ-011 SHALL have outputs busy (1), done (1, one-cycle pulse), shadow_valid (1) and restore_err (1, one-cycle pulse).

Function
REQ-012 SHALL use states IDLE, SAVE_A, SAVE_X, SAVE_Y, SAVE_Z, RST_A, RST_X, RST_Y and RST_Z.
REQ-013 SHALL go from IDLE to SAVE_A on trap_enter and to RST_A on trap_exit; if both are high in the same cycle, save wins and the exit is latched as pending.
REQ-014 SHALL, in SAVE_x, drive map_reg_rd_sel with x's index, write map_reg_data into shadow[x] at the clock edge, then advance; SAVE_Z goes to IDLE and sets shadow_valid.
REQ-015 SHALL, in RST_x with map=0, assert hypervisor_load_user_reg with map_reg_write_sel = x's index and map_wr_data = shadow[x], then advance; RST_Z goes to IDLE.
REQ-016 SHALL, in RST_x with map=1, hold state and keep hypervisor_load_user_reg low (stall); the stall has no timeout.
REQ-017 SHALL complete a save in 4 cycles: trap_enter sampled at edge E0, captures at E1..E4, done high for the cycle after E4.
REQ-018 SHALL complete a restore in 4 cycles plus the number of map=1 stall cycles, with done timed as in REQ-017.
REQ-019 SHALL, on trap_exit with shadow_valid=0, issue no writes, go to no RST state, and pulse done and restore_err together on the next cycle.
REQ-020 SHALL latch at most one pending save and one pending restore while busy (duplicates are dropped), start them on the cycle after returning to IDLE, and run a pending save before a pending restore.
REQ-021 SHALL give the save capture priority over shadow_we to the same index in the same cycle; shadow_we to any other index always applies.
REQ-022 SHALL drive busy high in any non-IDLE state and low in IDLE.
REQ-023 SHALL drive hypervisor_load_user_reg low outside RST states.
REQ-024 SHALL make shadow_rd_data reflect shadow writes from the cycle after the write edge.

Reset
REQ-025 SHALL, on reset, set state=IDLE, clear both pending bits, set shadow[0..3]=0x00 and shadow_valid=0, and drive busy, done, restore_err and hypervisor_load_user_reg to 0 and map_reg_rd_sel, map_reg_write_sel and map_wr_data to 0.
REQ-026 SHALL, on reset mid-save or mid-restore, abandon the operation with no done pulse; mapper writes already issued stand.

Structure
REQ-027 SHALL take the index constants (MAP_IDX_A=3, MAP_IDX_X=2, MAP_IDX_Y=1, MAP_IDX_Z=0) and the state encoding from shared package mapper4510_pkg.
REQ-028 SHALL implement the 4x8 shadow array, with its capture and write-priority logic, as sub-module mapper4510_shadow_rf.

Verification
REQ-029 SHALL cover: mapper A/X/Y/Z=12/34/56/78 + trap_enter -> shadow 12/34/56/78 after 4 cycles, done on the 5th, shadow_valid=1.
REQ-030 SHALL cover: shadow 9A/BC/DE/F0 valid + trap_exit with map=0 -> 4 write strobes, sel 3,2,1,0 with data 9A,BC,DE,F0, done on the 5th cycle.
REQ-031 SHALL cover: restore with map=1 for 3 cycles at RST_Y -> RST_Y held, no strobe, done 3 cycles later (cycle 8).
REQ-032 SHALL cover: trap_exit after reset -> no strobes, done and restore_err pulse on cycle 1.
REQ-033 SHALL cover: trap_enter and trap_exit in the same cycle -> full save, then restore starting one cycle after save done, writing back the saved values.
REQ-034 SHALL cover: reset asserted in SAVE_Y -> next cycle IDLE, busy=0, shadow all 00, no done pulse.

Source files
------------

// File: rtl/mapper4510_pkg.sv
// Shared definitions for the 4510 mapper hypervisor context save/restore.
// Holds the register index constants, the state encoding and small helpers
// that map a state onto the mapper register it works on.
package mapper4510_pkg;

    // Mapper register indices as seen on the readback/write select buses.
    localparam logic [1:0] MAP_IDX_A = 2'd3;
    localparam logic [1:0] MAP_IDX_X = 2'd2;
    localparam logic [1:0] MAP_IDX_Y = 2'd1;
    localparam logic [1:0] MAP_IDX_Z = 2'd0;

    // Number of shadow bytes, one per mapper register.
    localparam int SHADOW_DEPTH = 4;

    // Sequencer states: one per register for both the save and the restore walk.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SAVE_A = 4'd1,
        SAVE_X = 4'd2,
        SAVE_Y = 4'd3,
        SAVE_Z = 4'd4,
        RST_A  = 4'd5,
        RST_X  = 4'd6,
        RST_Y  = 4'd7,
        RST_Z  = 4'd8
    } ctx_state_t;

    // Register index handled by a given state (Z for IDLE, which never uses it).
    function automatic logic [1:0] state_idx(input ctx_state_t s);
        logic [1:0] idx;
        case (s)
            SAVE_A, RST_A: idx = MAP_IDX_A;
            SAVE_X, RST_X: idx = MAP_IDX_X;
            SAVE_Y, RST_Y: idx = MAP_IDX_Y;
            default:       idx = MAP_IDX_Z;
        endcase
        return idx;
    endfunction

    // Successor of a state once its register has been handled.
    function automatic ctx_state_t next_step(input ctx_state_t s);
        ctx_state_t n;
        case (s)
            SAVE_A:  n = SAVE_X;
            SAVE_X:  n = SAVE_Y;
            SAVE_Y:  n = SAVE_Z;
            RST_A:   n = RST_X;
            RST_X:   n = RST_Y;
            RST_Y:   n = RST_Z;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic is_save_state(input ctx_state_t s);
        return (s == SAVE_A) || (s == SAVE_X) || (s == SAVE_Y) || (s == SAVE_Z);
    endfunction

    function automatic logic is_rst_state(input ctx_state_t s);
        return (s == RST_A) || (s == RST_X) || (s == RST_Y) || (s == RST_Z);
    endfunction

endpackage

// File: rtl/mapper4510_shadow_rf.sv
// Four-byte shadow copy of the user mapper registers.
// Two write sources: the save sequencer capture and the hypervisor port.
// When both target the same byte in one cycle the capture wins, so a save
// always records the true mapper contents. Reads are combinational.
module mapper4510_shadow_rf
    import mapper4510_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cap_en,
    input  logic [1:0] cap_sel,
    input  logic [7:0] cap_data,
    input  logic       we,
    input  logic [1:0] wr_sel,
    input  logic [7:0] wr_data,
    input  logic [1:0] rd_sel,
    output logic [7:0] rd_data,
    input  logic [1:0] rst_sel,
    output logic [7:0] rst_data
);

    logic [SHADOW_DEPTH-1:0][7:0] shadow_q;

    generate
        for (genvar gi = 0; gi < SHADOW_DEPTH; gi++) begin : g_entry
            logic [7:0] entry_reg;

            // One shadow byte: cleared on reset, capture beats hypervisor write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (cap_en && (cap_sel == 2'(gi))) begin
                    entry_reg <= cap_data;
                end else if (we && (wr_sel == 2'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign shadow_q[gi] = entry_reg;
        end
    endgenerate

    // Hypervisor read port and restore-data read port.
    assign rd_data  = shadow_q[rd_sel];
    assign rst_data = shadow_q[rst_sel];

endmodule

// File: rtl/mapper4510_hyper_ctx.sv
// Hypervisor trap context engine for the 4510 mapper.
// On trap entry the user A/X/Y/Z mapper registers are read back one per
// cycle into a shadow; on trap exit the shadow is written back one per cycle,
// stalling while the mapper is busy executing MAP. Requests that arrive while
// a walk is in progress are remembered (one of each kind) and run afterwards,
// save first.
module mapper4510_hyper_ctx
    import mapper4510_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       trap_enter,
    input  logic       trap_exit,
    input  logic       map,
    input  logic [7:0] map_reg_data,
    output logic [1:0] map_reg_rd_sel,
    output logic [1:0] map_reg_write_sel,
    output logic       hypervisor_load_user_reg,
    output logic [7:0] map_wr_data,
    input  logic [1:0] shadow_rd_sel,
    output logic [7:0] shadow_rd_data,
    input  logic       shadow_we,
    input  logic [1:0] shadow_wr_sel,
    input  logic [7:0] shadow_wr_data,
    output logic       busy,
    output logic       done,
    output logic       shadow_valid,
    output logic       restore_err
);

    ctx_state_t state_reg;
    ctx_state_t state_next;

    logic pend_save_reg;
    logic pend_save_next;
    logic pend_rst_reg;
    logic pend_rst_next;
    logic valid_reg;
    logic valid_next;
    logic done_reg;
    logic done_next;
    logic err_reg;
    logic err_next;

    logic       go_save;
    logic       go_rst;
    logic       cap_en;
    logic       load_en;
    logic [1:0] cur_idx;
    logic [7:0] rst_data;

    assign cur_idx = state_idx(state_reg);

    mapper4510_shadow_rf u_shadow_rf (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap_en),
        .cap_sel  (cur_idx),
        .cap_data (map_reg_data),
        .we       (shadow_we),
        .wr_sel   (shadow_wr_sel),
        .wr_data  (shadow_wr_data),
        .rd_sel   (shadow_rd_sel),
        .rd_data  (shadow_rd_data),
        .rst_sel  (cur_idx),
        .rst_data (rst_data)
    );

    // Sequencer state, pending requests, shadow-valid flag and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pend_save_reg <= 1'b0;
            pend_rst_reg  <= 1'b0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_save_reg <= pend_save_next;
            pend_rst_reg  <= pend_rst_next;
            valid_reg     <= valid_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic: start requests in IDLE, walk the registers otherwise.
    always_comb begin
        state_next     = state_reg;
        pend_save_next = pend_save_reg;
        pend_rst_next  = pend_rst_reg;
        valid_next     = valid_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        cap_en         = 1'b0;
        load_en        = 1'b0;
        go_save        = trap_enter | pend_save_reg;
        go_rst         = trap_exit | pend_rst_reg;

        if (state_reg == IDLE) begin
            if (go_save) begin
                // A simultaneous exit must wait until the save has finished.
                state_next     = SAVE_A;
                pend_save_next = 1'b0;
                pend_rst_next  = go_rst;
            end else if (go_rst) begin
                pend_rst_next = 1'b0;
                if (valid_reg) begin
                    state_next = RST_A;
                end else begin
                    // Nothing saved yet: refuse without touching the mapper.
                    done_next = 1'b0 | 1'b1;
                    err_next  = 1'b1;
                end
            end
        end else begin
            // Remember at most one request of each kind while busy.
            pend_save_next = pend_save_reg | trap_enter;
            pend_rst_next  = pend_rst_reg | trap_exit;

            if (is_save_state(state_reg)) begin
                cap_en     = 1'b1;
                state_next = next_step(state_reg);
                if (state_reg == SAVE_Z) begin
                    valid_next = 1'b1;
                    done_next  = 1'b1;
                end
            end else if (!map) begin
                // Writes to the mapper are held off while MAP is executing.
                load_en    = 1'b1;
                state_next = next_step(state_reg);
                if (state_reg == RST_Z) begin
                    done_next = 1'b1;
                end
            end
        end
    end

    // Mapper-facing outputs, forced quiet while reset is asserted.
    always_comb begin
        busy                     = 1'b0;
        map_reg_rd_sel           = MAP_IDX_Z;
        map_reg_write_sel        = MAP_IDX_Z;
        map_wr_data              = 8'h00;
        hypervisor_load_user_reg = 1'b0;
        if (!reset) begin
            busy = (state_reg != IDLE);
            if (is_save_state(state_reg)) begin
                map_reg_rd_sel = cur_idx;
            end
            if (is_rst_state(state_reg)) begin
                map_reg_write_sel        = cur_idx;
                map_wr_data              = rst_data;
                hypervisor_load_user_reg = load_en;
            end
        end
    end

    assign done         = done_reg;
    assign restore_err  = err_reg;
    assign shadow_valid = valid_reg;

endmodule
